dct4_pipe: RTL
==============

DCT4_PIPE -- requirements
Module: dct4_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed input sample width (range 4..16).
REQ-002 SHALL have parameter ROWS, default 4, vectors per block for out_last generation (range 1..256).
REQ-003 SHALL derive localparam OUT_W = DATA_W+8, the signed output width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, input vector present.
REQ-007 SHALL have port in_ready, output, 1, block accepts the vector this cycle.
REQ-008 SHALL have ports x0, x1, x2, x3, input, DATA_W each, signed samples.
REQ-009 SHALL have port clear, input, 1, synchronous clear of row counter and pipeline.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have ports y0, y1, y2, y3, output, OUT_W each, signed coefficients.
REQ-013 SHALL have port out_last, output, 1, result is the final vector of a ROWS block.

Function
REQ-014 Transfer SHALL occur on a cycle with valid and ready both high, on each side independently.
REQ-015 Stage 1 SHALL register a0=x0+x3, a1=x1+x2, b0=x0-x3, b1=x1-x2, each DATA_W+1 bits signed, with no truncation.
REQ-016 Stage 2 SHALL register y0=(a0+a1)<<6, y2=(a0-a1)<<6, y1=(b1+2*b0)<<5, y3=(b0-2*b1)<<5, computed at full width and sign-extended to OUT_W, with no overflow for any input.
REQ-017 Latency from accepted input to out_valid SHALL be 2 cycles when out_ready stays high.
REQ-018 Throughput SHALL be 1 vector per cycle with no bubbles while out_ready is high.
REQ-019 Stage 2 SHALL load when out_ready is high or stage 2 is empty.
REQ-020 Stage 1 SHALL load when stage 2 loads or stage 1 is empty.
REQ-021 in_ready SHALL be high when stage 1 is empty or stage 1 advances this cycle; in_ready is combinational from out_ready.
REQ-022 While out_valid is high and out_ready is low, y0..y3 and out_last SHALL be held stable.
REQ-023 A row counter SHALL increment on each accepted input and wrap from ROWS-1 to 0.
REQ-024 A per-stage last flag SHALL be set for an input accepted at count ROWS-1 and travel with its data; out_last SHALL equal that flag.
REQ-025 With ROWS=1, every result SHALL carry out_last=1.
REQ-026 clear SHALL zero the counter and invalidate both stages on the next edge; in_ready SHALL be low during clear, and a simultaneous input SHALL be dropped.

Reset
REQ-027 Asserting rst SHALL immediately force out_valid=0, out_last=0, y0..y3=0, stage valids=0, and row counter=0, regardless of clk.
REQ-028 Data in flight when rst asserts mid-operation SHALL be discarded; after deassertion the first accepted input SHALL be row 0.

Structure
REQ-029 Package dct4_pkg SHALL hold the shift constants (SH_EVEN=6, SH_ODD=5), the OUT_W derivation function, and the stage-1 struct typedef (a0, a1, b0, b1, last).
REQ-030 One sub-module, dct4_pipe_stage, SHALL implement the parametrised valid/ready register slice and be instantiated twice.

Verification
REQ-031 x=(10,20,30,40), out_ready=1 -> 2 cycles later y0=6400, y1=-2240, y2=0, y3=-320.
REQ-032 All x=127, then all x=-128 -> y0=32512, then y0=-32768, with y1=y2=y3=0 for both; no wrap.
REQ-033 Stream 8 vectors back-to-back with ROWS=4 -> 8 consecutive results; out_last on the 4th and 8th.
REQ-034 Hold out_ready=0 for 5 cycles mid-stream -> in_ready drops after the stages fill, outputs stay stable, and no vector is lost or duplicated.
REQ-035 Assert rst asynchronously between edges with 2 vectors in flight -> outputs are 0 at once; the next accepted vector yields out_last only after ROWS inputs.
REQ-036 Pulse clear with in_valid=1 after 2 of 4 rows -> the pipeline empties, the input is dropped, and the counter restarts at 0.

Source files
------------

// File: rtl/dct4_pkg.sv
// Shared constants, output-width helper and stage-1 record for the 4-point DCT pipe.
package dct4_pkg;
  localparam int SH_EVEN = 6;
  localparam int SH_ODD  = 5;
  localparam int MAX_DW  = 16;
  localparam int S1_W    = MAX_DW + 1;

  function automatic int out_w(input int data_w);
    return data_w + 8;
  endfunction

  // Butterfly terms sized for the widest legal DATA_W; narrower inputs are sign-extended.
  typedef struct packed {
    logic signed [S1_W-1:0] a0;
    logic signed [S1_W-1:0] a1;
    logic signed [S1_W-1:0] b0;
    logic signed [S1_W-1:0] b1;
    logic                   last;
  } s1_t;
endpackage

// File: rtl/dct4_pipe_stage.sv
// One valid/ready register slice: loads when downstream takes the held entry or the slice is empty.
module dct4_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = out_ready | ~valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/dct4_pipe.sv
// Two-stage 4-point integer DCT with valid/ready flow control and per-block last marking.
module dct4_pipe
  import dct4_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ROWS   = 4,
  localparam int OUT_W  = out_w(DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x0,
  input  logic signed [DATA_W-1:0] x1,
  input  logic signed [DATA_W-1:0] x2,
  input  logic signed [DATA_W-1:0] x3,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  y0,
  output logic signed [OUT_W-1:0]  y1,
  output logic signed [OUT_W-1:0]  y2,
  output logic signed [OUT_W-1:0]  y3,
  output logic                     out_last
);
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int S2_W  = 4*OUT_W + 1;

  logic [CNT_W-1:0] row_q, row_d;
  logic             s1_in_valid, s1_in_ready, s1_valid, s2_in_ready, accept;
  s1_t              s1_d, s1_q;
  logic [S2_W-1:0]  s2_d, s2_q;
  logic signed [OUT_W-1:0] e0, e1, e2, e3;

  // clear blocks the input side so a coincident vector is neither loaded nor counted.
  assign s1_in_valid = in_valid & ~clear;
  assign in_ready    = s1_in_ready & ~clear;
  assign accept      = in_valid & in_ready;

  always_comb begin
    row_d = row_q;
    if (accept) row_d = (row_q == CNT_W'(ROWS-1)) ? '0 : row_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        row_q <= '0;
    else if (clear) row_q <= '0;
    else            row_q <= row_d;
  end

  always_comb begin
    s1_d.a0   = S1_W'(x0) + S1_W'(x3);
    s1_d.a1   = S1_W'(x1) + S1_W'(x2);
    s1_d.b0   = S1_W'(x0) - S1_W'(x3);
    s1_d.b1   = S1_W'(x1) - S1_W'(x2);
    s1_d.last = (row_q == CNT_W'(ROWS-1));
  end

  dct4_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_q)
  );

  // Full-precision butterfly; magnitudes always fit OUT_W so truncation drops only sign copies.
  always_comb begin
    e0 = OUT_W'((32'($signed(s1_q.a0)) + 32'($signed(s1_q.a1))) <<< SH_EVEN);
    e2 = OUT_W'((32'($signed(s1_q.a0)) - 32'($signed(s1_q.a1))) <<< SH_EVEN);
    e1 = OUT_W'((32'($signed(s1_q.b1)) + (32'($signed(s1_q.b0)) <<< 1)) <<< SH_ODD);
    e3 = OUT_W'((32'($signed(s1_q.b0)) - (32'($signed(s1_q.b1)) <<< 1)) <<< SH_ODD);
    s2_d = {e0, e1, e2, e3, s1_q.last};
  end

  dct4_pipe_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign {y0, y1, y2, y3, out_last} = s2_q;
endmodule
